// File: rtl/smg_decoder.sv
// Receive-side decoder for a 6-digit common-anode multiplexed 7-segment bus.
// Samples each digit after it settles, decodes it to hex and reports full 24-bit frames.
module smg_decoder #(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 100_000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [7:0]  smg_data,
  input  logic [5:0]  scan_sig,
  output logic [23:0] number_sig,
  output logic        number_valid,
  output logic        frame_err
);

  localparam logic [0:0]  ST_IDLE    = 1'b0;
  localparam logic [0:0]  ST_COLLECT = 1'b1;
  localparam logic [7:0]  SETTLE_V   = 8'(SETTLE);
  localparam logic [7:0]  SETTLE_M1  = 8'(SETTLE - 1);
  localparam logic [16:0] TIMEOUT_M1 = 17'(TIMEOUT - 1);
  localparam logic [2:0]  NO_DIGIT   = 3'd7;

  logic [5:0]  scan_r, scan_p;
  logic [7:0]  seg_r, seg_p;
  logic [7:0]  stab;
  logic [16:0] tmo;
  logic [0:0]  state;
  logic [19:0] shadow;
  logic        err_acc;
  logic [2:0]  expect_k;
  logic [2:0]  last_digit;

  logic [2:0]  digit;
  logic        legal, blank, illegal, changed, sample;
  logic [4:0]  dec;
  logic [3:0]  nib;
  logic        bad;

  // Common-anode, active-low table with dp masked; result is {no_match, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h10: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    digit = NO_DIGIT;
    for (int i = 0; i < 6; i++) begin
      if (!scan_r[i]) digit = 3'(i);
    end
    legal   = $onehot(~scan_r);
    blank   = &scan_r;
    illegal = !legal && !blank;
    changed = {scan_r, seg_r} != {scan_p, seg_p};
    sample  = legal && !changed && (stab == SETTLE_M1);
    dec     = decode(seg_r[6:0]);
    nib     = dec[3:0];
    bad     = dec[4];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scan_r <= 6'h3F;
      seg_r  <= 8'hFF;
      scan_p <= 6'h3F;
      seg_p  <= 8'hFF;
      stab   <= '0;
    end else begin
      scan_r <= scan_sig;
      seg_r  <= smg_data;
      scan_p <= scan_r;
      seg_p  <= seg_r;
      if (changed || !legal)    stab <= '0;
      else if (stab != SETTLE_V) stab <= stab + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= ST_IDLE;
      number_sig   <= '0;
      number_valid <= 1'b0;
      frame_err    <= 1'b0;
      tmo          <= '0;
      shadow       <= '0;
      err_acc      <= 1'b0;
      expect_k     <= '0;
      last_digit   <= NO_DIGIT;
    end else begin
      number_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sample && digit == 3'd0 && digit != last_digit) begin
            shadow[3:0] <= nib;
            err_acc     <= bad;
            expect_k    <= 3'd1;
            last_digit  <= 3'd0;
            tmo         <= '0;
            state       <= ST_COLLECT;
          end
        end
        default: begin
          if (illegal) begin
            frame_err  <= 1'b1;
            last_digit <= NO_DIGIT;
            state      <= ST_IDLE;
          end else if (sample && digit != last_digit) begin
            tmo <= '0;
            if (digit == expect_k) begin
              err_acc    <= err_acc | bad;
              expect_k   <= expect_k + 3'd1;
              last_digit <= digit;
              if (digit != 3'd5) begin
                shadow[5'(digit) * 5'd4 +: 4] <= nib;
              end else begin
                if (!(err_acc || bad)) begin
                  number_sig   <= {nib, shadow};
                  number_valid <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                end
                last_digit <= NO_DIGIT;
                state      <= ST_IDLE;
              end
            end else begin
              frame_err <= 1'b1;
              if (digit == 3'd0) begin
                shadow[3:0] <= nib;
                err_acc     <= bad;
                expect_k    <= 3'd1;
                last_digit  <= 3'd0;
              end else begin
                last_digit <= NO_DIGIT;
                state      <= ST_IDLE;
              end
            end
          end else if (tmo == TIMEOUT_M1) begin
            frame_err  <= 1'b1;
            last_digit <= NO_DIGIT;
            state      <= ST_IDLE;
          end else begin
            tmo <= tmo + 17'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smg_decoder.sv
// Bench for smg_decoder: directed scenarios plus random frames, checked against a
// frame-level model of how sampled digits become frames, errors and values.
module tb_smg_decoder;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 200;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [7:0]  smg_data;
  logic [5:0]  scan_sig;
  logic [23:0] number_sig;
  logic        number_valid;
  logic        frame_err;

  smg_decoder #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .smg_data     (smg_data),
    .scan_sig     (scan_sig),
    .number_sig   (number_sig),
    .number_valid (number_valid),
    .frame_err    (frame_err)
  );

  always #5 CLK = ~CLK;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pulse monitor: counts high cycles so a stretched or extra pulse shows up.
  int n_valid = 0, n_err = 0, n_both = 0;
  int e_valid = 0, e_err = 0;
  always @(negedge CLK) begin
    if (RSTn) begin
      if (number_valid) n_valid++;
      if (frame_err) n_err++;
      if (number_valid && frame_err) n_both++;
    end
  end

  // Frame-level reference: what each accepted digit sample does to the frame.
  int          m_exp;
  int          m_last;
  logic        m_acc;
  logic [3:0]  m_dig [6];
  logic [23:0] m_num;

  task automatic model_reset();
    m_exp = -1; m_last = 7; m_acc = 1'b0; m_num = '0;
  endtask

  task automatic model_abort();
    m_exp = -1; m_last = 7; e_err++;
  endtask

  task automatic model_start(input logic b, input logic [3:0] nib);
    m_dig[0] = nib; m_acc = b; m_exp = 1; m_last = 0;
  endtask

  // kind: 0 = nothing visible, 1 = valid frame, 2 = frame error
  task automatic model_sample(input int k, input logic b, input logic [3:0] nib, output int kind);
    kind = 0;
    if (k == m_last) return;
    if (m_exp < 0) begin
      if (k == 0) model_start(b, nib);
      return;
    end
    if (k == m_exp) begin
      m_dig[k] = nib;
      m_acc = m_acc | b;
      m_exp++;
      m_last = k;
      if (k == 5) begin
        if (!m_acc) begin
          m_num = {m_dig[5], m_dig[4], m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
          kind = 1;
        end else begin
          kind = 2;
        end
        m_exp = -1; m_last = 7;
      end
    end else begin
      kind = 2;
      if (k == 0) model_start(b, nib);
      else begin m_exp = -1; m_last = 7; end
    end
    if (kind == 1) e_valid++;
    if (kind == 2) e_err++;
  endtask

  // One 10-cycle dwell, driver style: segments change one cycle before scan.
  // Called on a negedge; returns on the negedge that starts the next dwell.
  task automatic dwell(input int k, input logic [7:0] seg, input logic b,
                       input logic [3:0] nib, input bit glitch);
    int kind;
    model_sample(k, b, nib, kind);
    smg_data = seg;
    @(negedge CLK);
    scan_sig = ~(6'b000001 << k);
    for (int i = 2; i <= 10; i++) begin
      @(negedge CLK);
      if (i == 6) begin
        check("early_valid", 24'(number_valid), 24'd0);
        check("early_err", 24'(frame_err), 24'd0);
      end
      if (i == 7) begin
        check($sformatf("valid_d%0d", k), 24'(number_valid), 24'(kind == 1));
        check($sformatf("err_d%0d", k), 24'(frame_err), 24'(kind == 2));
        check($sformatf("value_d%0d", k), number_sig, m_num);
      end
      if (glitch && i == 8) smg_data = 8'h80;
      if (glitch && i == 10) smg_data = seg;
    end
  endtask

  task automatic digit(input int k, input logic [3:0] nib);
    logic [7:0] s;
    s = seg_tab[nib] & {1'($urandom_range(0, 1)), 7'h7F};
    dwell(k, s, 1'b0, nib, 1'b0);
  endtask

  // bad_pos: digit with an undecodable pattern; skip_pos: digit never shown;
  // glitch_pos: digit with a 2-cycle segment glitch after its sample.
  task automatic frame(input logic [23:0] v, input int bad_pos, input int skip_pos,
                       input int glitch_pos);
    logic [3:0] nib;
    for (int k = 0; k < 6; k++) begin
      nib = v[4*k +: 4];
      if (k == skip_pos) continue;
      if (k == bad_pos) dwell(k, 8'hFF, 1'b1, 4'h0, 1'b0);
      else if (k == glitch_pos) dwell(k, seg_tab[nib], 1'b0, nib, 1'b1);
      else digit(k, nib);
    end
  endtask

  task automatic idle_bus(input int n);
    scan_sig = 6'h3F;
    smg_data = 8'hFF;
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RSTn = 1'b0;
    scan_sig = 6'h3F;
    smg_data = 8'hFF;
    model_reset();
    #12;
    check("rst_value", number_sig, 24'h0);
    check("rst_valid", 24'(number_valid), 24'd0);
    check("rst_err", 24'(frame_err), 24'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    idle_bus(3);

    // Clean frame, then the same frame with a short glitch on digit 2.
    frame(24'h12A5F0, -1, -1, -1);
    frame(24'h12A5F0, -1, -1, 2);
    // Undecodable digit 3: error, value held.
    frame(24'h345678, 3, -1, -1);

    // Mid-frame start is ignored, then a full frame, then an out-of-order digit.
    digit(3, 4'h1); digit(4, 4'h2); digit(5, 4'h3);
    frame(24'hFFFFFF, -1, -1, -1);
    digit(0, 4'h5); digit(1, 4'h6); digit(3, 4'h7);

    // Timeout: no sample for TIMEOUT cycles after digit 2.
    digit(0, 4'h1); digit(1, 4'h2); digit(2, 4'h3);
    scan_sig = 6'h3F;
    smg_data = 8'hFF;
    repeat (TIMEOUT - 4) @(negedge CLK);
    check("tmo_early", 24'(frame_err), 24'd0);
    @(negedge CLK);
    check("tmo_err", 24'(frame_err), 24'd1);
    model_abort();
    idle_bus(3);

    // Illegal scan during collection.
    digit(0, 4'h9);
    scan_sig = 6'b111100;
    @(negedge CLK);
    check("illegal_early", 24'(frame_err), 24'd0);
    @(negedge CLK);
    check("illegal_err", 24'(frame_err), 24'd1);
    model_abort();
    idle_bus(3);

    // Reset in the middle of digit 4.
    frame(24'hABCDEF, -1, 4, -1);
    smg_data = seg_tab[4'hB];
    @(negedge CLK);
    scan_sig = 6'b101111;
    repeat (3) @(negedge CLK);
    RSTn = 1'b0;
    #1;
    check("mid_rst_value", number_sig, 24'h0);
    check("mid_rst_valid", 24'(number_valid), 24'd0);
    check("mid_rst_err", 24'(frame_err), 24'd0);
    model_reset();
    idle_bus(2);
    RSTn = 1'b1;
    idle_bus(2);
    frame(24'h000001, -1, -1, -1);

    // Random frames with random faults.
    for (int n = 0; n < 20; n++) begin
      logic [23:0] v;
      int f;
      v = 24'($urandom);
      f = int'($urandom_range(0, 3));
      if (f == 2)      frame(v, int'($urandom_range(0, 5)), -1, -1);
      else if (f == 3) frame(v, -1, int'($urandom_range(1, 5)), -1);
      else             frame(v, -1, -1, -1);
    end
    frame(24'h5A5A5A, -1, -1, -1);
    idle_bus(5);

    check("valid_pulses", 24'(n_valid), 24'(e_valid));
    check("err_pulses", 24'(n_err), 24'(e_err));
    check("pulse_overlap", 24'(n_both), 24'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
